// File: rtl/mult_dispatcher.sv
// Job feeder for the leading-one approximate multiplier: buffers operand pairs,
// launches one job at a time, bypasses zero operands and captures products.
module mult_dispatcher #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               start,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic               mult_done,
    input  logic [2*WIDTH-1:0] mult_res,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_res,
    output logic               busy,
    output logic               err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned WD_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   fifo_a [DEPTH];
    logic [WIDTH-1:0]   fifo_b [DEPTH];

    logic               push, pop, bypass, capture, abort;
    logic               fifo_empty, out_free, head_zero;
    logic [WIDTH-1:0]   head_a, head_b;

    assign push       = in_valid & in_ready;
    assign fifo_empty = (count_q == '0);
    assign out_free   = ~out_valid | out_ready;
    assign head_a     = fifo_a[rd_ptr_q];
    assign head_b     = fifo_b[rd_ptr_q];
    assign head_zero  = ~(|head_a) | ~(|head_b);

    // Next-state and per-cycle control decode
    always_comb begin
        state_d = state_q;
        wdog_d  = wdog_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && out_free) begin
                    pop = 1'b1;
                    if (head_zero) bypass  = 1'b1;
                    else           state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
                wdog_d  = '0;
            end
            S_WAIT: begin
                if (mult_done) begin
                    capture = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                    // Abort once the job has spent TIMEOUT cycles in WAIT
                    if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                        abort   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    // FSM state, watchdog and FIFO bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            wdog_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            in_ready <= 1'b1;
        end else begin
            state_q  <= state_d;
            wdog_q   <= wdog_d;
            count_q  <= count_d;
            in_ready <= (count_d != CNT_W'(DEPTH));
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Operand storage carries no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr_q] <= in_a;
            fifo_b[wr_ptr_q] <= in_b;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start     <= 1'b0;
            busy      <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            out_valid <= 1'b0;
            out_res   <= '0;
            err       <= 1'b0;
        end else begin
            start <= (state_d == S_START);
            busy  <= (state_d != S_IDLE);
            if (pop) begin
                op_a <= head_a;
                op_b <= head_b;
            end
            if (capture) begin
                out_res   <= mult_res;
                out_valid <= 1'b1;
            end else if (bypass) begin
                out_res   <= '0;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (abort) err <= 1'b1;
        end
    end

endmodule
